// File: rtl/date_seq_converter_if.sv
// date_seq_converter_if: start/advance request and calendar-date result bundle
//   master: drives start, day_of_year, leap_year, advance; receives the result
//   slave : the converter; receives requests, drives busy/valid/error/date/year_wrap
interface date_seq_converter_if #(parameter int DOY_WIDTH = 9);
    logic                 start;
    logic [DOY_WIDTH-1:0] day_of_year;
    logic                 leap_year;
    logic                 advance;
    logic                 busy;
    logic                 valid;
    logic                 error;
    logic [3:0]           month;
    logic [1:0]           day_tens;
    logic [3:0]           day_ones;
    logic                 year_wrap;
    modport master(output start, day_of_year, leap_year, advance,
                   input busy, valid, error, month, day_tens, day_ones, year_wrap);
    modport slave(input start, day_of_year, leap_year, advance,
                  output busy, valid, error, month, day_tens, day_ones, year_wrap);
endinterface

// File: rtl/date_seq_converter.sv
// date_seq_converter: multi-cycle day-of-year to month/BCD-day converter with a held, advanceable date
//   clk, reset (async, active-high)
//   bus.start/day_of_year/leap_year : conversion request, sampled when idle
//   bus.advance                     : step the held date one day, sampled when idle
//   bus.busy/valid/error            : status; valid pulses once per new date or error
//   bus.month/day_tens/day_ones     : held date; bus.year_wrap pulses on 12/31 -> 1/01
module date_seq_converter #(
    parameter int DOY_WIDTH  = 9,
    parameter int LEAP_MONTH = 2
) (
    input logic               clk,
    input logic               reset,
    date_seq_converter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, SUB, BCD, DONE} state_t;

    state_t               state_q, state_d;
    logic [DOY_WIDTH-1:0] rem_q, rem_d;
    logic                 leap_q, leap_d;
    logic [3:0]           mon_cnt_q, mon_cnt_d;
    logic [1:0]           tens_cnt_q, tens_cnt_d;
    logic                 bad_q, bad_d;
    logic [3:0]           month_q, month_d;
    logic [1:0]           day_tens_q, day_tens_d;
    logic [3:0]           day_ones_q, day_ones_d;
    logic                 error_q, error_d;
    logic                 held_q, held_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;

    function automatic logic [4:0] mlen(input logic [3:0] m, input logic lp);
        logic [4:0] l;
        l = (m == 4'd2) ? 5'd28 :
            (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
        return l + {4'd0, lp && (m == 4'(LEAP_MONTH))};
    endfunction

    logic [4:0] sub_len, adv_len, day_bin;

    always_comb begin
        sub_len    = mlen(mon_cnt_q, leap_q);
        adv_len    = mlen(month_q, leap_q);
        day_bin    = 5'(day_tens_q) * 5'd10 + 5'(day_ones_q);
        state_d    = state_q;
        rem_d      = rem_q;
        leap_d     = leap_q;
        mon_cnt_d  = mon_cnt_q;
        tens_cnt_d = tens_cnt_q;
        bad_d      = bad_q;
        month_d    = month_q;
        day_tens_d = day_tens_q;
        day_ones_d = day_ones_q;
        error_d    = error_q;
        held_d     = held_q;
        valid_d    = 1'b0;
        wrap_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d      = bus.day_of_year;
                    leap_d     = bus.leap_year;
                    mon_cnt_d  = 4'd1;
                    tens_cnt_d = 2'd0;
                    state_d    = CHECK;
                end else if (bus.advance && held_q) begin
                    valid_d = 1'b1;
                    if (day_bin < adv_len) begin
                        day_ones_d = (day_ones_q == 4'd9) ? 4'd0 : day_ones_q + 4'd1;
                        day_tens_d = (day_ones_q == 4'd9) ? day_tens_q + 2'd1 : day_tens_q;
                    end else begin
                        day_tens_d = 2'd0;
                        day_ones_d = 4'd1;
                        month_d    = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
                        wrap_d     = (month_q == 4'd12);
                    end
                end
            end
            CHECK: begin
                // An out-of-range request drains through BCD with nothing left to
                // convert, so every result (good or bad) is loaded at one place.
                bad_d   = (rem_q == '0) ||
                          (rem_q > (leap_q ? DOY_WIDTH'(366) : DOY_WIDTH'(365)));
                rem_d   = bad_d ? '0 : rem_q;
                state_d = bad_d ? BCD : SUB;
            end
            SUB: begin
                if (rem_q > DOY_WIDTH'(sub_len)) begin
                    rem_d     = rem_q - DOY_WIDTH'(sub_len);
                    mon_cnt_d = mon_cnt_q + 4'd1;
                end else begin
                    state_d = BCD;
                end
            end
            BCD: begin
                if (rem_q >= DOY_WIDTH'(10)) begin
                    rem_d      = rem_q - DOY_WIDTH'(10);
                    tens_cnt_d = tens_cnt_q + 2'd1;
                end else begin
                    state_d    = DONE;
                    valid_d    = 1'b1;
                    error_d    = bad_q;
                    month_d    = bad_q ? 4'd0 : mon_cnt_q;
                    day_tens_d = bad_q ? 2'd0 : tens_cnt_q;
                    day_ones_d = bad_q ? 4'd0 : rem_q[3:0];
                end
            end
            DONE: begin
                held_d  = !error_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            leap_q     <= 1'b0;
            mon_cnt_q  <= 4'd0;
            tens_cnt_q <= 2'd0;
            bad_q      <= 1'b0;
            month_q    <= 4'd0;
            day_tens_q <= 2'd0;
            day_ones_q <= 4'd0;
            error_q    <= 1'b0;
            held_q     <= 1'b0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            leap_q     <= leap_d;
            mon_cnt_q  <= mon_cnt_d;
            tens_cnt_q <= tens_cnt_d;
            bad_q      <= bad_d;
            month_q    <= month_d;
            day_tens_q <= day_tens_d;
            day_ones_q <= day_ones_d;
            error_q    <= error_d;
            held_q     <= held_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.busy      = (state_q == CHECK) || (state_q == SUB) || (state_q == BCD);
    assign bus.valid     = valid_q;
    assign bus.error     = error_q;
    assign bus.month     = month_q;
    assign bus.day_tens  = day_tens_q;
    assign bus.day_ones  = day_ones_q;
    assign bus.year_wrap = wrap_q;
endmodule

// File: tb/tb_date_seq_converter.sv
// tb_date_seq_converter: directed and randomized checks against a calendar reference model
module tb_date_seq_converter;
    localparam int W = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    date_seq_converter_if #(.DOY_WIDTH(W)) bus();
    date_seq_converter #(.DOY_WIDTH(W), .LEAP_MONTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit held = 0;
    bit hl = 0;
    int em = 0;
    int ed = 0;
    bit ee = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mlen(input int m, input bit lp);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return t[m-1] + ((lp && m == 2) ? 1 : 0);
    endfunction

    function automatic void model(input int doy, input bit lp, output int m, output int d, output bit e);
        e = (doy < 1) || (doy > (lp ? 366 : 365));
        m = 0;
        d = 0;
        if (!e) begin
            m = 1;
            d = doy;
            while (d > mlen(m, lp)) begin
                d -= mlen(m, lp);
                m++;
            end
        end
    endfunction

    task automatic chk_date(input string tag);
        chk({tag, "_month"}, 32'(bus.month), em);
        chk({tag, "_tens"}, 32'(bus.day_tens), ed / 10);
        chk({tag, "_ones"}, 32'(bus.day_ones), ed % 10);
        chk({tag, "_error"}, 32'(bus.error), 32'(ee));
    endtask

    task automatic convert(input int doy, input bit lp, input bit adv_too);
        int m, d, n, lat;
        bit e;
        model(doy, lp, m, d, e);
        lat = e ? 2 : 3 + (m - 1) + d / 10;
        bus.day_of_year = W'(doy);
        bus.leap_year = lp;
        bus.advance = adv_too;
        bus.start = 1'b1;
        tick;
        bus.advance = 1'b0;
        bus.day_of_year = W'($urandom_range(0, 511));
        bus.leap_year = ~lp;
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("hold_while_busy", 32'(bus.month), em);
        n = 0;
        while (!bus.valid && n < 40) begin
            tick;
            n++;
            bus.start = 1'b0;
            if (!bus.valid) chk("busy_during", 32'(bus.busy), 1);
        end
        em = m;
        ed = d;
        ee = e;
        held = !e;
        hl = lp;
        chk("latency", n, lat);
        chk("busy_at_valid", 32'(bus.busy), 0);
        chk("wrap_at_conv", 32'(bus.year_wrap), 0);
        chk_date("conv");
        tick;
        chk("valid_one_cycle", 32'(bus.valid), 0);
        chk_date("conv_hold");
    endtask

    task automatic advance_step;
        bit w;
        bit v;
        w = 0;
        v = held;
        bus.advance = 1'b1;
        tick;
        bus.advance = 1'b0;
        if (held) begin
            if (ed < mlen(em, hl)) ed++;
            else if (em < 12) begin
                em++;
                ed = 1;
            end else begin
                em = 1;
                ed = 1;
                w = 1;
            end
        end
        chk("adv_valid", 32'(bus.valid), 32'(v));
        chk("adv_wrap", 32'(bus.year_wrap), 32'(w));
        chk_date("adv");
        tick;
        chk("adv_valid_drop", 32'(bus.valid), 0);
        chk("adv_wrap_drop", 32'(bus.year_wrap), 0);
    endtask

    initial begin
        int vcount;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.advance = 1'b0;
        bus.day_of_year = '0;
        bus.leap_year = 1'b0;
        tick;
        tick;
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_wrap", 32'(bus.year_wrap), 0);
        chk_date("rst");
        reset = 1'b0;
        tick;
        advance_step;
        convert(1, 0, 0);
        convert(60, 0, 0);
        convert(60, 1, 0);
        convert(366, 1, 0);
        convert(366, 0, 0);
        convert(0, 0, 0);
        convert(59, 0, 0);
        advance_step;
        convert(59, 1, 0);
        advance_step;
        advance_step;
        convert(365, 0, 0);
        advance_step;
        advance_step;
        convert(400, 1, 0);
        advance_step;
        convert(200, 1, 0);
        bus.day_of_year = W'(200);
        bus.leap_year = 1'b0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        #1 reset = 1'b1;
        #1;
        em = 0;
        ed = 0;
        ee = 0;
        held = 0;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_valid", 32'(bus.valid), 0);
        chk_date("mid_rst");
        tick;
        tick;
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.valid) vcount++;
        end
        chk("no_valid_after_abort", vcount, 0);
        advance_step;
        convert(100, 0, 1);
        for (int i = 0; i < 40; i++) begin
            bit lp;
            int doy;
            lp = 1'($urandom_range(0, 1));
            doy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(1, 366));
            convert(doy, lp, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 4)) advance_step;
        end
        convert(365, 1, 0);
        repeat (3) advance_step;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
